// File: rtl/uart_line_rx.sv
// uart_line_rx: assembles one text line from the uart_rx byte stream
// and replays it downstream with a valid/ready handshake and a last flag.
module uart_line_rx #(
    parameter int CLK_FRE    = 50,
    parameter int MAX_LEN    = 32,
    parameter int TIMEOUT_MS = 10,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recv_en,
    input  logic [7:0]       recv_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [LEN_W-1:0] line_len,
    output logic             ovf,
    output logic             lost,
    output logic             timeout
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [31:0] TO_LAST = 32'(CLK_FRE * 1000 * TIMEOUT_MS - 1);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [1:0] {
        RECV,
        GOT_CR,
        DROP,
        OUT
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] wr_q, wr_d;
    logic [LEN_W-1:0] rd_q, rd_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             lost_q, lost_d;
    logic             to_q, to_d;
    logic             buf_we;
    logic             running;
    logic [7:0]       mem [MAX_LEN];

    // State, pointer, length, idle counter and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RECV;
            wr_q    <= '0;
            rd_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            lost_q  <= lost_d;
            to_q    <= to_d;
        end
    end

    // Line buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem[wr_q[AW-1:0]] <= recv_data;
        end
    end

    // Next-state logic: assembly, termination, overflow, idle timeout, replay
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        len_d   = len_q;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        lost_d  = 1'b0;
        to_d    = 1'b0;
        buf_we  = 1'b0;
        running = (state_q == GOT_CR) || (state_q == RECV && wr_q != '0);

        unique case (state_q)
            RECV, GOT_CR: begin
                if (recv_en) begin
                    if (recv_data == LF) begin
                        if (wr_q == '0) begin
                            state_d = RECV;
                        end else begin
                            len_d   = wr_q;
                            rd_d    = '0;
                            state_d = OUT;
                        end
                    end else if (recv_data == CR) begin
                        state_d = GOT_CR;
                    end else if (wr_q < MAX_L) begin
                        buf_we  = 1'b1;
                        wr_d    = wr_q + LEN_W'(1);
                        state_d = RECV;
                    end else begin
                        ovf_d   = 1'b1;
                        wr_d    = '0;
                        state_d = DROP;
                    end
                end else if (running) begin
                    if (cnt_q == TO_LAST) begin
                        to_d    = 1'b1;
                        wr_d    = '0;
                        state_d = RECV;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            DROP: begin
                if (recv_en && recv_data == LF) begin
                    wr_d    = '0;
                    state_d = RECV;
                end
            end
            OUT: begin
                lost_d = recv_en;
                if (out_ready) begin
                    if (rd_q == len_q - LEN_W'(1)) begin
                        wr_d    = '0;
                        rd_d    = '0;
                        state_d = RECV;
                    end else begin
                        rd_d = rd_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    assign out_valid = (state_q == OUT);
    assign out_data  = out_valid ? mem[rd_q[AW-1:0]] : 8'h00;
    assign out_last  = out_valid && (rd_q == len_q - LEN_W'(1));
    assign line_len  = len_q;
    assign ovf       = ovf_q;
    assign lost      = lost_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: directed vectors for uart_line_rx with
// hand-computed expected bytes, flags and pulse timing.
module tb_uart_line_rx;

    localparam int LEN_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             recv_en;
    logic [7:0]       recv_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic [LEN_W-1:0] line_len;
    logic             ovf;
    logic             lost;
    logic             timeout;

    int n_chk  = 0;
    int n_fail = 0;

    uart_line_rx #(
        .CLK_FRE   (1),
        .MAX_LEN   (32),
        .TIMEOUT_MS(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .recv_en  (recv_en),
        .recv_data(recv_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .line_len (line_len),
        .ovf      (ovf),
        .lost     (lost),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        recv_en   = 1'b1;
        recv_data = b;
        tick();
        recv_en   = 1'b0;
        recv_data = 8'h00;
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] d,
                            input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".last"}, 32'(out_last), 32'(last));
    endtask

    initial begin
        rst       = 1'b1;
        recv_en   = 1'b0;
        recv_data = 8'h00;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.last", 32'(out_last), 32'd0);
        check("rst.len", 32'(line_len), 32'd0);
        check("rst.pulses", {29'd0, ovf, lost, timeout}, 32'd0);
        rst = 1'b0;
        tick();

        // "AB\r\n", ready held high
        send(8'h41);
        send(8'h42);
        send(8'h0D);
        check("ab.cr_wait", 32'(out_valid), 32'd0);
        send(8'h0A);
        check("ab.len", 32'(line_len), 32'd2);
        chk_byte("ab0", 8'h41, 1'b0);
        tick();
        chk_byte("ab1", 8'h42, 1'b1);
        tick();
        check("ab.done", 32'(out_valid), 32'd0);

        // "hi\n" with 5 stalled cycles
        out_ready = 1'b0;
        send(8'h68);
        send(8'h69);
        send(8'h0A);
        for (int i = 0; i < 5; i++) begin
            chk_byte("hi.stall", 8'h68, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        chk_byte("hi0", 8'h68, 1'b0);
        tick();
        chk_byte("hi1", 8'h69, 1'b1);
        tick();
        check("hi.done", 32'(out_valid), 32'd0);

        // 33 bytes overflow a 32-byte line
        for (int i = 0; i < 32; i++) send(8'h30 + 8'(i % 10));
        check("ovf.before", 32'(ovf), 32'd0);
        send(8'h7A);
        check("ovf.pulse", 32'(ovf), 32'd1);
        tick();
        check("ovf.one", 32'(ovf), 32'd0);
        send(8'h0A);
        check("ovf.noline", 32'(out_valid), 32'd0);
        send(8'h58);
        send(8'h0A);
        check("x.len", 32'(line_len), 32'd1);
        chk_byte("x0", 8'h58, 1'b1);
        tick();
        check("x.done", 32'(out_valid), 32'd0);

        // empty lines, and a CR inside the payload
        send(8'h0D);
        send(8'h0A);
        check("empty1", 32'(out_valid), 32'd0);
        send(8'h0D);
        send(8'h0D);
        send(8'h0A);
        check("empty2", 32'(out_valid), 32'd0);
        send(8'h61);
        send(8'h0D);
        send(8'h62);
        send(8'h0A);
        check("acrb.len", 32'(line_len), 32'd2);
        chk_byte("acrb0", 8'h61, 1'b0);
        tick();
        chk_byte("acrb1", 8'h62, 1'b1);
        tick();
        check("acrb.done", 32'(out_valid), 32'd0);

        // idle timeout after "Q": 1000 cycles
        send(8'h51);
        repeat (999) tick();
        check("to.early", 32'(timeout), 32'd0);
        tick();
        check("to.pulse", 32'(timeout), 32'd1);
        tick();
        check("to.one", 32'(timeout), 32'd0);
        send(8'h5A);
        send(8'h0A);
        check("z.len", 32'(line_len), 32'd1);
        chk_byte("z0", 8'h5A, 1'b1);
        tick();
        check("z.done", 32'(out_valid), 32'd0);

        // byte dropped during OUT, then reset mid-line
        out_ready = 1'b0;
        send(8'h4D);
        send(8'h4E);
        send(8'h0A);
        chk_byte("mn.first", 8'h4D, 1'b0);
        send(8'h31);
        check("lost.pulse", 32'(lost), 32'd1);
        tick();
        check("lost.one", 32'(lost), 32'd0);
        check("mn.len", 32'(line_len), 32'd2);
        chk_byte("mn.hold", 8'h4D, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2.valid", 32'(out_valid), 32'd0);
        check("rst2.len", 32'(line_len), 32'd0);
        out_ready = 1'b1;
        send(8'h6F);
        send(8'h6B);
        send(8'h0A);
        check("ok.len", 32'(line_len), 32'd2);
        chk_byte("ok0", 8'h6F, 1'b0);
        tick();
        chk_byte("ok1", 8'h6B, 1'b1);
        tick();
        check("ok.done", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_rx.md
Name: uart_line_rx

Overview:
Receive-side line assembler. It consumes the byte stream from uart_rx, buffers one text line terminated by "\r\n" or a bare "\n", then replays the line as a byte stream with valid/ready handshake and a last flag. It is the receiving counterpart of the transmit-side string sender in uart_top, and the first stage of a future command parser.

Parameters:
CLK_FRE, 50, clock frequency in MHz.
MAX_LEN, 32, maximum payload bytes per line, terminator excluded; range 2..255.
TIMEOUT_MS, 10, inter-byte idle timeout in ms; a partial line is discarded when it expires.
LEN_W, $clog2(MAX_LEN+1), derived width of the length fields.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
recv_en  in  1  one-cycle strobe from uart_rx; recv_data is valid in that cycle
recv_data  in  8  received byte
out_valid  out  1  out_data holds a line byte
out_ready  in  1  downstream accepts the byte when out_valid is also high
out_data  out  8  line byte, in order of reception
out_last  out  1  high with the final byte of the line
line_len  out  LEN_W  payload length; stable while in OUT
ovf  out  1  one-cycle pulse when a line exceeds MAX_LEN
lost  out  1  one-cycle pulse when a byte arrives during OUT and is dropped
timeout  out  1  one-cycle pulse when a partial line is discarded on idle

Behaviour:
- Reset: state=RECV; wr_ptr=0, rd_ptr=0; all outputs 0. Buffer contents are don't-care. Reset in any state, including mid-OUT, abandons the line and emits no pulse.
- Storage: MAX_LEN x 8 register or RAM buffer. wr_ptr is the write index and the length counter.
- States: RECV, GOT_CR, DROP, OUT.
- RECV, on recv_en:
  - 0x0D goes to GOT_CR.
  - 0x0A completes the line.
  - Any other byte: if wr_ptr<MAX_LEN, store buf[wr_ptr] and increment wr_ptr. Otherwise pulse ovf next cycle, clear wr_ptr, go to DROP.
- GOT_CR, on recv_en:
  - 0x0A completes the line.
  - 0x0D stays in GOT_CR.
  - Any other byte: the pending CR is discarded and the byte is handled exactly as in RECV.
- Completion:
  - wr_ptr==0 (empty line): no output, return to RECV.
  - Otherwise latch line_len=wr_ptr, rd_ptr=0, enter OUT. out_valid rises the cycle after the terminator strobe (latency 1).
- DROP: discard all bytes; on 0x0A return to RECV with wr_ptr=0. No line is emitted for the overflowed line.
- OUT:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==line_len-1).
  - On out_valid&&out_ready: rd_ptr increments. If the transfer was the last byte, the next cycle has out_valid=0, wr_ptr=0, state=RECV.
  - out_data and out_last must hold stable while out_valid&&!out_ready.
  - recv_en in OUT: byte dropped, lost pulses the next cycle. This includes terminators.
  - A recv_en coinciding with the final handshake is also dropped.
- Timeout:
  - The counter runs in RECV/GOT_CR when wr_ptr>0 or state==GOT_CR. Any recv_en clears it.
  - At CLK_FRE*1000*TIMEOUT_MS cycles: pulse timeout, clear wr_ptr, go to RECV.
  - The counter is held at 0 in OUT and DROP. DROP itself never times out.
- Pulse outputs (ovf, lost, timeout) are exactly one cycle wide; back-to-back events give back-to-back pulses.
- Arithmetic: pointer compares are unsigned at LEN_W bits; no pointer wraps past MAX_LEN.

Test Plan:
- Strobe "AB\r\n" (0x41,0x42,0x0D,0x0A) with out_ready=1 -> out 0x41 then 0x42; out_last only on 0x42; line_len=2; out_valid low afterward.
- Strobe "hi\n", hold out_ready=0 for 5 cycles then 1 -> out_data=0x68 stable for 5 cycles; then 0x68, 0x69 with last on 0x69.
- Strobe 33 non-terminator bytes then "\n" with MAX_LEN=32 -> single ovf pulse after byte 33; no out_valid; the next line "X\n" outputs 0x58 with last.
- Strobe "\r\n" and "\r\r\n" -> no output; strobe "a\rb\n" -> out 0x61, 0x62; line_len=2.
- Strobe "Q" then idle (TIMEOUT_MS=1, CLK_FRE=1 -> 1000 cycles) -> timeout pulse at cycle 1000; following "Z\n" outputs only 0x5A.
- During OUT with out_ready=0, strobe 0x31 -> lost pulse; the line is unchanged. Then assert rst mid-OUT -> out_valid=0 the next cycle; state RECV; a fresh "ok\n" outputs correctly.
